// File: rtl/radix4_pkg.sv
// Shared encodings for the radix-4 Booth sequencer, its load/select decoder and the datapath.
package radix4_pkg;

   localparam int STATE_W = 3;
   typedef logic [STATE_W-1:0] state_t;

   localparam state_t S_IDLE  = 3'b000;
   localparam state_t S_LOAD  = 3'b001;
   localparam state_t S_EVAL  = 3'b010;
   localparam state_t S_ADD   = 3'b011;
   localparam state_t S_SHIFT = 3'b100;
   localparam state_t S_DONE  = 3'b101;

   // Booth digit as seen by the adder: sign, magnitude-two and zero flags.
   typedef struct packed {
      logic neg;
      logic dbl;
      logic zero;
   } booth_op_t;

   localparam booth_op_t OP_ZERO = 3'b001;
   localparam booth_op_t OP_POS1 = 3'b000;
   localparam booth_op_t OP_POS2 = 3'b010;
   localparam booth_op_t OP_NEG2 = 3'b110;
   localparam booth_op_t OP_NEG1 = 3'b100;

endpackage

// File: rtl/radix4_seq_if.sv
// Control/status bundle between the Booth sequencer and its datapath.
interface radix4_seq_if
   import radix4_pkg::*;
#(
   parameter int N  = 8,
   parameter int CW = $clog2(N/2+1)
);
   logic          start;
   logic [2:0]    booth3;
   state_t        state;
   logic          busy;
   logic          done;
   logic          op_neg;
   logic          op_dbl;
   logic          op_zero;
   logic [CW-1:0] iter;

   modport master (
      output start, booth3,
      input  state, busy, done, op_neg, op_dbl, op_zero, iter
   );

   modport slave (
      input  start, booth3,
      output state, busy, done, op_neg, op_dbl, op_zero, iter
   );
endinterface

// File: rtl/radix4_booth_dec.sv
// Combinational radix-4 Booth digit decode of {q[1], q[0], q[-1]}.
module radix4_booth_dec
   import radix4_pkg::*;
(
   input  logic [2:0] i_booth3,
   output booth_op_t  o_op
);

   always_comb begin
      o_op = OP_ZERO;
      case (i_booth3)
         3'b000, 3'b111: o_op = OP_ZERO;
         3'b001, 3'b010: o_op = OP_POS1;
         3'b011:         o_op = OP_POS2;
         3'b100:         o_op = OP_NEG2;
         default:        o_op = OP_NEG1;
      endcase
   end

endmodule

// File: rtl/radix4_seq.sv
// Radix-4 Booth multiply sequencer: FSM, remaining-digit counter and registered Booth op.
module radix4_seq
   import radix4_pkg::*;
#(
   parameter int N  = 8,
   parameter int CW = $clog2(N/2+1)
)(
   input  logic        clk,
   input  logic        rst,
   radix4_seq_if.slave bus
);

   localparam int            K     = N / 2;
   localparam logic [CW-1:0] K_CNT = CW'(K);

   if ((N < 4) || ((N % 2) != 0)) begin : g_bad_n
      $error("radix4_seq: N must be even and at least 4");
   end

   state_t        r_state;
   state_t        w_next;
   logic [CW-1:0] r_iter;
   booth_op_t     r_op;
   booth_op_t     w_op;
   logic          w_busy;
   logic          w_done;
   logic          w_last;

   radix4_booth_dec u_dec (
      .i_booth3 (bus.booth3),
      .o_op     (w_op)
   );

   // A counter at 0 in SHIFT can only follow a corrupted run; finish rather than loop.
   assign w_last = (r_iter <= CW'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = S_IDLE;
      case (r_state)
         S_IDLE:  w_next = bus.start ? S_LOAD : S_IDLE;
         S_LOAD:  w_next = S_EVAL;
         S_EVAL:  w_next = w_op.zero ? S_SHIFT : S_ADD;
         S_ADD:   w_next = S_SHIFT;
         S_SHIFT: w_next = w_last ? S_DONE : S_EVAL;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_busy = (r_state != S_IDLE);
      w_done = (r_state == S_DONE);
   end

   // Clearing on every entry to IDLE also covers recovery from the unused codes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                        r_iter <= '0;
      else if (w_next == S_IDLE)                      r_iter <= '0;
      else if (r_state == S_LOAD)                     r_iter <= K_CNT;
      else if ((r_state == S_SHIFT) && (r_iter != 0)) r_iter <= r_iter - CW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                      r_op <= '0;
      else if (r_state == S_LOAD)   r_op <= '0;
      else if (r_state == S_EVAL)   r_op <= w_op;
   end

   assign bus.state   = r_state;
   assign bus.busy    = w_busy;
   assign bus.done    = w_done;
   assign bus.op_neg  = r_op.neg;
   assign bus.op_dbl  = r_op.dbl;
   assign bus.op_zero = r_op.zero;
   assign bus.iter    = r_iter;

endmodule

// File: tb/tb_radix4_seq.sv
// Directed bench for radix4_seq (N = 8) with hand-computed state sequences and latencies.
module tb_radix4_seq;
   import radix4_pkg::*;

   localparam int N = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_pass = 0;

   logic [2:0] state_log [0:31];
   logic [2:0] op_log    [0:31];
   int         iter_log  [0:31];

   radix4_seq_if #(.N(N)) bus_if ();

   radix4_seq #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic int ops();
      return {bus_if.op_neg, bus_if.op_dbl, bus_if.op_zero};
   endfunction

   // One multiply; digit d of pat (pat[3d+:3]) is presented while the FSM sits in EVAL.
   task automatic run_mult(input logic [11:0] pat, input bit pulse, input bit hold,
                           output int done_cyc, output int n_add, output int n_done,
                           output int reload_cyc);
      int d;
      d = 0; done_cyc = -1; n_add = 0; n_done = 0; reload_cyc = -1;
      @(negedge clk);
      bus_if.start  = 1'b1;
      bus_if.booth3 = pat[2:0];
      for (int c = 1; c <= 30; c++) begin
         @(posedge clk); #1;
         if (!hold) bus_if.start = pulse && (c == 3 || c == 5);
         state_log[c] = bus_if.state;
         op_log[c]    = 3'(ops());
         iter_log[c]  = int'(bus_if.iter);
         if (bus_if.state == S_EVAL && d < 4) begin
            bus_if.booth3 = pat[3*d +: 3];
            d++;
         end
         if (bus_if.state == S_ADD) n_add++;
         if (bus_if.done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (hold && done_cyc > 0 && bus_if.state == S_LOAD) begin
            reload_cyc = c;
            break;
         end
         if (!hold && c > 1 && bus_if.state == S_IDLE) break;
      end
      bus_if.start = 1'b0;
   endtask

   int dc, na, nd, rc, extra_done, got_add;
   logic [2:0] seq0 [1:11] = '{3'b001, 3'b010, 3'b100, 3'b010, 3'b100, 3'b010,
                               3'b100, 3'b010, 3'b100, 3'b101, 3'b000};

   initial begin
      bus_if.start  = 1'b0;
      bus_if.booth3 = 3'b000;

      repeat (2) @(posedge clk);
      #1;
      check("rst_state", int'(bus_if.state), 0);
      check("rst_busy",  int'(bus_if.busy), 0);
      check("rst_done",  int'(bus_if.done), 0);
      check("rst_ops",   ops(), 0);
      check("rst_iter",  int'(bus_if.iter), 0);
      @(negedge clk);
      rst = 1'b0;

      // All-zero digits: EVAL/SHIFT only.
      run_mult(12'h000, 1'b0, 1'b0, dc, na, nd, rc);
      check("zero_done_cyc", dc, 10);
      check("zero_done_cnt", nd, 1);
      check("zero_add_cnt",  na, 0);
      for (int c = 1; c <= 11; c++) check($sformatf("zero_seq_c%0d", c), int'(state_log[c]), int'(seq0[c]));
      check("zero_iter_c2",  iter_log[2], 4);
      check("zero_iter_c10", iter_log[10], 0);
      check("zero_op_c3",    int'(op_log[3]), 1);
      check("zero_op_c10",   int'(op_log[10]), 1);

      // Multiplier 0x55: every digit +1.
      run_mult(12'b010_010_010_010, 1'b0, 1'b0, dc, na, nd, rc);
      check("x55_done_cyc", dc, 14);
      check("x55_add_cnt",  na, 4);
      check("x55_op_c3",    int'(op_log[3]), 0);

      // Multiplier 0xFF: -1 then three zero digits.
      run_mult(12'b111_111_111_110, 1'b0, 1'b0, dc, na, nd, rc);
      check("xff_done_cyc", dc, 11);
      check("xff_add_cnt",  na, 1);
      check("xff_op_c3",    int'(op_log[3]), 3'b100);
      check("xff_op_done",  int'(op_log[dc > 0 ? dc : 0]), 3'b001);

      // +2 and -2 digits.
      run_mult(12'b000_000_000_011, 1'b0, 1'b0, dc, na, nd, rc);
      check("p2_op_c3",    int'(op_log[3]), 3'b010);
      check("p2_done_cyc", dc, 11);
      run_mult(12'b000_000_000_100, 1'b0, 1'b0, dc, na, nd, rc);
      check("m2_op_c3",    int'(op_log[3]), 3'b110);
      check("m2_done_cyc", dc, 11);

      // Start pulses while busy are ignored.
      run_mult(12'h000, 1'b1, 1'b0, dc, na, nd, rc);
      check("pulse_done_cyc", dc, 10);
      check("pulse_done_cnt", nd, 1);
      @(posedge clk); #1;
      check("pulse_idle_after", int'(bus_if.state), 0);

      // Start held through DONE: reload two cycles after done.
      run_mult(12'h000, 1'b0, 1'b1, dc, na, nd, rc);
      check("hold_done_cyc", dc, 10);
      check("hold_done_cnt", nd, 1);
      check("hold_reload_gap", rc - dc, 2);
      extra_done = 0;
      bus_if.booth3 = 3'b000;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         if (bus_if.done) extra_done++;
         if (bus_if.state == S_IDLE) break;
      end
      check("hold_second_done", extra_done, 1);

      // Asynchronous reset in the middle of an ADD.
      @(negedge clk);
      bus_if.start  = 1'b1;
      bus_if.booth3 = 3'b100;
      got_add = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         bus_if.start = 1'b0;
         if (bus_if.state == S_ADD) begin
            got_add = 1;
            break;
         end
      end
      check("rstmid_reached_add", got_add, 1);
      check("rstmid_ops_before",  ops(), 3'b110);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rstmid_state", int'(bus_if.state), 0);
      check("rstmid_busy",  int'(bus_if.busy), 0);
      check("rstmid_done",  int'(bus_if.done), 0);
      check("rstmid_iter",  int'(bus_if.iter), 0);
      check("rstmid_ops",   ops(), 0);
      @(negedge clk);
      rst = 1'b0;
      run_mult(12'b010_010_010_010, 1'b0, 1'b0, dc, na, nd, rc);
      check("postrst_done_cyc", dc, 14);
      check("postrst_done_cnt", nd, 1);

      // Unused state codes recover to IDLE without a done pulse.
      for (int k = 6; k <= 7; k++) begin
         @(negedge clk);
         force dut.r_state = 3'(k);
         #1;
         check($sformatf("ill%0d_forced", k), int'(bus_if.state), k);
         release dut.r_state;
         @(posedge clk); #1;
         check($sformatf("ill%0d_state", k), int'(bus_if.state), 0);
         check($sformatf("ill%0d_done",  k), int'(bus_if.done), 0);
         check($sformatf("ill%0d_iter",  k), int'(bus_if.iter), 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
